// File: rtl/cic_pkg.sv
// Shared constants and state encoding for the CIC decimator controller.
package cic_pkg;

    localparam int unsigned CIC_ORDER  = 3;
    localparam int unsigned CIC_RATE_W = 8;

    typedef logic [1:0] cic_state_t;

    localparam cic_state_t ST_IDLE   = 2'b00;
    localparam cic_state_t ST_FLUSH  = 2'b01;
    localparam cic_state_t ST_SETTLE = 2'b10;
    localparam cic_state_t ST_RUN    = 2'b11;

endpackage

// File: rtl/cic_dec_cnt.sv
// Decimation counter: counts qualified input samples modulo rate and emits a
// registered one-cycle strobe after the last sample of each block.
module cic_dec_cnt
    import cic_pkg::*;
#(
    parameter int unsigned RATE_W = CIC_RATE_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              vld,
    input  logic [RATE_W-1:0] rate,
    output logic              stb
);

    logic [RATE_W-1:0] cnt_q;
    logic              stb_q;
    logic              last;

    assign last = (cnt_q == rate - RATE_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
        end else begin
            stb_q <= vld & last;
            if (vld) begin
                cnt_q <= last ? '0 : cnt_q + RATE_W'(1);
            end
        end
    end

    assign stb = stb_q;

endmodule

// File: rtl/cic_ctrl.sv
// Control FSM for a CIC decimator: flush, settle, run and graceful stop.
// Optional output-sample counter enabled by defining CIC_CTRL_SAMPLE_CNT_EN.
module cic_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned ORDER  = CIC_ORDER,
    parameter int unsigned RATE_W = CIC_RATE_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic [RATE_W-1:0] rate_i,
    input  logic              src_vld,
    output logic              cic_en,
    output logic              cic_zero,
    output logic              dec_stb,
    output logic              out_vld,
    output logic [1:0]        state_o,
    output logic              busy,
    output logic              err_rate
`ifdef CIC_CTRL_SAMPLE_CNT_EN
    ,
    output logic [31:0]       sample_cnt
`endif
);

    localparam int unsigned FLUSH_W  = RATE_W + $clog2(ORDER) + 1;
    localparam int unsigned SETTLE_W = $clog2(ORDER + 1);

    cic_state_t          state_q, state_d;
    logic [RATE_W-1:0]   rate_q;
    logic [FLUSH_W-1:0]  flush_cnt_q;
    logic [FLUSH_W-1:0]  flush_len;
    logic [SETTLE_W-1:0] settle_cnt_q;
    logic                stop_pend_q;
    logic                err_rate_q;
    logic                accept, reject;
    logic                flush_done, settle_done;
    logic                active;
    logic                stb;

    // SETTLE and RUN share the top state bit.
    assign active = state_q[1];

    assign accept = (state_q == ST_IDLE) && start && !stop && (rate_i >= RATE_W'(2));
    assign reject = (state_q == ST_IDLE) && start && !stop && (rate_i <  RATE_W'(2));

    assign flush_len   = FLUSH_W'(ORDER) * FLUSH_W'(rate_q);
    assign flush_done  = (flush_cnt_q == flush_len - FLUSH_W'(1));
    assign settle_done = dec_stb && (settle_cnt_q == SETTLE_W'(ORDER - 1));

    cic_dec_cnt #(
        .RATE_W (RATE_W)
    ) u_dec_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (!active),
        .vld  (src_vld & active),
        .rate (rate_q),
        .stb  (stb)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (stop)            state_d = ST_IDLE;
                else if (flush_done) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (stop_pend_q && dec_stb) state_d = ST_IDLE;
                else if (settle_done)       state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_pend_q && dec_stb) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            rate_q       <= '0;
            flush_cnt_q  <= '0;
            settle_cnt_q <= '0;
            stop_pend_q  <= 1'b0;
            err_rate_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_rate_q <= reject;
            if (accept) begin
                rate_q <= rate_i;
            end
            flush_cnt_q <= (state_q == ST_FLUSH) ? flush_cnt_q + FLUSH_W'(1) : '0;
            if (state_q != ST_SETTLE) begin
                settle_cnt_q <= '0;
            end else if (dec_stb) begin
                settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
            end
            // A stop seen in SETTLE/RUN waits for the next strobe to finish the block.
            if (!active || state_d == ST_IDLE) begin
                stop_pend_q <= 1'b0;
            end else if (stop) begin
                stop_pend_q <= 1'b1;
            end
        end
    end

    assign dec_stb  = stb & active;
    assign out_vld  = dec_stb & (state_q == ST_RUN);
    assign cic_zero = (state_q == ST_FLUSH);
    assign cic_en   = (state_q == ST_FLUSH) | (active & src_vld);
    assign state_o  = state_q;
    assign busy     = (state_q != ST_IDLE);
    assign err_rate = err_rate_q;

`ifdef CIC_CTRL_SAMPLE_CNT_EN
    logic [31:0] sample_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sample_cnt_q <= '0;
        end else if (accept) begin
            sample_cnt_q <= '0;
        end else if (out_vld && (sample_cnt_q != '1)) begin
            sample_cnt_q <= sample_cnt_q + 32'd1;
        end
    end

    assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_cic_ctrl.sv
// Self-checking bench for cic_ctrl: strobe scoreboard plus direct state checks.
module tb_cic_ctrl;
    import cic_pkg::*;

    localparam int unsigned ORDER  = 3;
    localparam int unsigned RATE_W = 8;

    logic              clk     = 1'b0;
    logic              rstn    = 1'b1;
    logic              start   = 1'b0;
    logic              stop    = 1'b0;
    logic              src_vld = 1'b0;
    logic [RATE_W-1:0] rate_i  = '0;
    logic              cic_en, cic_zero, dec_stb, out_vld, busy, err_rate;
    logic [1:0]        state_o;
`ifdef CIC_CTRL_SAMPLE_CNT_EN
    logic [31:0]       sample_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit tog      = 1'b0;

    typedef struct {
        int   cyc;
        logic ov;
    } stb_t;
    stb_t sbq[$];

    cic_ctrl #(
        .ORDER  (ORDER),
        .RATE_W (RATE_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .rate_i   (rate_i),
        .src_vld  (src_vld),
        .cic_en   (cic_en),
        .cic_zero (cic_zero),
        .dec_stb  (dec_stb),
        .out_vld  (out_vld),
        .state_o  (state_o),
        .busy     (busy),
        .err_rate (err_rate)
`ifdef CIC_CTRL_SAMPLE_CNT_EN
        ,
        .sample_cnt (sample_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] outs();
        return {cic_en, cic_zero, dec_stb, out_vld, busy, err_rate, state_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) src_vld = ~cyc[0];
    endtask

    task automatic go(input int n);
        while (cyc < n) tick();
    endtask

    task automatic at(input int n);
        go(n);
        @(negedge clk);
    endtask

    task automatic expect_stb(input int c, input logic ov);
        stb_t e;
        e.cyc = c;
        e.ov  = ov;
        sbq.push_back(e);
    endtask

    // Every strobe must match the next queued expectation in cycle and out_vld.
    always @(negedge clk) begin : mon
        stb_t e;
        if (rstn && dec_stb) begin
            if (sbq.size() == 0) begin
                check("stb_extra", {31'd0, dec_stb}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("stb_cyc", cyc, e.cyc);
                check("stb_ovld", {31'd0, out_vld}, {31'd0, e.ov});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        at(2);
        check("rst_outs", {24'd0, outs()}, 32'd0);
        go(3);
        rstn = 1'b1;

        // R=8 continuous input: 24 flush cycles, 3 silent strobes, then every 8.
        go(10);
        start = 1'b1; rate_i = 8'd8; src_vld = 1'b1;
        for (int k = 1; k <= 7; k++) expect_stb(35 + 8 * k, k > 3);
        go(11);
        start = 1'b0; rate_i = 8'd0;
        at(11);
        check("a_flush_state", state_o, ST_FLUSH);
        check("a_flush_zero", cic_zero, 1);
        check("a_flush_busy", busy, 1);
        at(34);
        check("a_flush_last", state_o, ST_FLUSH);
        at(35);
        check("a_settle_state", state_o, ST_SETTLE);
        check("a_settle_zero", cic_zero, 0);
        check("a_settle_en", cic_en, 1);
        at(59);
        check("a_settle_hold", state_o, ST_SETTLE);
        at(60);
        check("a_run_state", state_o, ST_RUN);
        at(62);
        start = 1'b1; rate_i = 8'd3;
        go(63);
        start = 1'b0;
        at(85);
        stop = 1'b1;
        go(86);
        stop = 1'b0;
        at(91);
        check("a_stop_pending", state_o, ST_RUN);
        at(92);
        check("a_stop_idle", state_o, ST_IDLE);
        check("a_sb_empty", sbq.size(), 0);

        // Rejected rates and start+stop collision.
        at(100);
        start = 1'b1; rate_i = 8'd1;
        go(101);
        start = 1'b0;
        at(101);
        check("b_err_r1", err_rate, 1);
        check("b_state_r1", state_o, ST_IDLE);
        check("b_busy_r1", busy, 0);
        at(102);
        check("b_err_clear", err_rate, 0);
        at(103);
        start = 1'b1; rate_i = 8'd0;
        go(104);
        start = 1'b0;
        at(104);
        check("b_err_r0", err_rate, 1);
        check("b_state_r0", state_o, ST_IDLE);
        check("b_busy_r0", busy, 0);
        at(106);
        start = 1'b1; stop = 1'b1; rate_i = 8'd5;
        go(107);
        start = 1'b0; stop = 1'b0;
        at(107);
        check("b_collide_err", err_rate, 0);
        check("b_collide_state", state_o, ST_IDLE);

        // R=4, stop while the decimation counter is at 1.
        at(120);
        start = 1'b1; rate_i = 8'd4;
        for (int k = 1; k <= 6; k++) expect_stb(133 + 4 * k, k > 3);
        go(121);
        start = 1'b0;
        at(154);
        stop = 1'b1;
        go(155);
        stop = 1'b0;
        at(156);
        check("c_hold_run", state_o, ST_RUN);
        at(157);
        check("c_final_run", state_o, ST_RUN);
        at(158);
        check("c_idle", state_o, ST_IDLE);
        check("c_sb_empty", sbq.size(), 0);

        // R=5 with src_vld alternating: one strobe every 10 cycles.
        go(170);
        start = 1'b1; rate_i = 8'd5; src_vld = 1'b1; tog = 1'b1;
        for (int k = 1; k <= 5; k++) expect_stb(185 + 10 * k, k > 3);
        go(171);
        start = 1'b0;
        at(173);
        check("d_flush_en", cic_en, 1);
        at(200);
        check("d_mirror_hi", cic_en, src_vld);
        at(201);
        check("d_mirror_lo", cic_en, src_vld);
        at(231);
        check("d_mirror_run", cic_en, src_vld);
        go(238);
        rstn = 1'b0;
        #1;
        check("d_rst_async", {24'd0, outs()}, 32'd0);
        tog = 1'b0; src_vld = 1'b1;
        at(239);
        check("d_rst_hold", {24'd0, outs()}, 32'd0);
        go(240);
        rstn = 1'b1;
        check("d_sb_empty", sbq.size(), 0);

        // Reset mid-FLUSH, then restart with R=2 (6 flush cycles).
        go(250);
        start = 1'b1; rate_i = 8'd8;
        go(251);
        start = 1'b0;
        go(255);
        rstn = 1'b0;
        #1;
        check("e_rst_async", {24'd0, outs()}, 32'd0);
        go(256);
        rstn = 1'b1;
        go(260);
        start = 1'b1; rate_i = 8'd2;
        for (int k = 1; k <= 5; k++) expect_stb(267 + 2 * k, k > 3);
        go(261);
        start = 1'b0;
        at(261);
        check("e_flush_first", state_o, ST_FLUSH);
        at(266);
        check("e_flush_last", state_o, ST_FLUSH);
        at(267);
        check("e_settle", state_o, ST_SETTLE);
        at(276);
        stop = 1'b1;
        go(277);
        stop = 1'b0;
        at(278);
        check("e_idle", state_o, ST_IDLE);
        check("e_sb_empty", sbq.size(), 0);

        // Stop during FLUSH returns to IDLE on the next edge.
        at(280);
        start = 1'b1; rate_i = 8'd6;
        go(281);
        start = 1'b0;
        at(281);
        check("f_flush", state_o, ST_FLUSH);
        stop = 1'b1;
        go(282);
        stop = 1'b0;
        at(282);
        check("f_idle", state_o, ST_IDLE);
        check("f_busy", busy, 0);

`ifdef CIC_CTRL_SAMPLE_CNT_EN
        at(300);
        start = 1'b1; rate_i = 8'd4;
        for (int k = 1; k <= 104; k++) expect_stb(313 + 4 * k, k > 3);
        go(301);
        start = 1'b0;
        at(301);
        check("g_cnt_start", sample_cnt, 0);
        at(726);
        check("g_cnt_100", sample_cnt, 100);
        stop = 1'b1;
        go(727);
        stop = 1'b0;
        at(730);
        check("g_cnt_final", sample_cnt, 101);
        check("g_idle", state_o, ST_IDLE);
        at(732);
        start = 1'b1;
        go(733);
        start = 1'b0;
        at(733);
        check("g_cnt_clear", sample_cnt, 0);
        stop = 1'b1;
        go(734);
        stop = 1'b0;
        at(734);
        check("g_idle2", state_o, ST_IDLE);
        check("g_sb_empty", sbq.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_ctrl.md
CIC_CTRL -- requirements
Module: cic_ctrl

Interface
REQ-001 Parameter ORDER, default 3: number of CIC integrator/comb stages.
REQ-002 Parameter RATE_W, default 8: width of the decimation-rate field.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a decimation run.
REQ-006 stop  input  1  single-cycle request to end the run.
REQ-007 rate_i  input  RATE_W  decimation rate R; sampled only on an accepted start.
REQ-008 src_vld  input  1  input sample present on the CIC din this cycle.
REQ-009 cic_en  output  1  drives the CIC en port.
REQ-010 cic_zero  output  1  forces the CIC din mux to zero.
REQ-011 dec_stb  output  1  one-cycle decimation strobe to the comb section.
REQ-012 out_vld  output  1  one-cycle qualified CIC output sample.
REQ-013 state_o  output  2  current state encoding.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 err_rate  output  1  one-cycle pulse on rejected start.

Function
REQ-016 The FSM SHALL have states IDLE=00, FLUSH=01, SETTLE=10 and RUN=11.
REQ-017 In IDLE, a start with rate_i>=2 SHALL latch rate_q=rate_i and enter FLUSH on the next edge.
REQ-018 In IDLE, a start with rate_i<2 SHALL pulse err_rate on the next cycle and remain in IDLE.
REQ-019 In IDLE, start and stop asserted together SHALL leave the FSM in IDLE with no err_rate.
REQ-020 FLUSH SHALL hold cic_en=1 and cic_zero=1 for exactly ORDER*rate_q cycles, then enter SETTLE.
REQ-021 In SETTLE and RUN, cic_en SHALL equal src_vld combinationally and cic_zero SHALL be 0.
REQ-022 The decimation counter SHALL count src_vld cycles 0..rate_q-1, wrap to 0, and hold when src_vld=0.
REQ-023 dec_stb SHALL assert, registered, one cycle after the src_vld cycle in which the counter is rate_q-1.
REQ-024 SETTLE SHALL suppress out_vld for the first ORDER dec_stb pulses, then enter RUN.
REQ-025 In RUN, out_vld SHALL equal dec_stb.
REQ-026 A stop in FLUSH SHALL enter IDLE on the next edge.
REQ-027 A stop in SETTLE or RUN SHALL be held pending; the FSM SHALL enter IDLE on the cycle its next dec_stb is issued, and that final out_vld SHALL still be issued.
REQ-028 A start outside IDLE SHALL be ignored, and rate_i changes SHALL have no effect until the next accepted start.
REQ-029 The flush counter SHALL be RATE_W+$clog2(ORDER)+1 bits wide so that ORDER*(2^RATE_W-1) does not overflow.

Reset
REQ-030 Asserting rstn low SHALL immediately force IDLE, clear all counters, clear rate_q and clear the pending-stop flag.
REQ-031 During reset, cic_en, cic_zero, dec_stb, out_vld, busy and err_rate SHALL be 0, and state_o SHALL be 00.
REQ-032 Reset asserted mid-run SHALL abort the run with no final strobe.

Configuration
REQ-033 When CIC_CTRL_SAMPLE_CNT_EN is defined, the block SHALL add the output port sample_cnt (32 bits), which counts out_vld pulses, clears on each accepted start and on reset, and saturates at 2^32-1.
REQ-034 When CIC_CTRL_SAMPLE_CNT_EN is not defined, the port and its counter SHALL be absent.

Structure
REQ-035 Package cic_pkg SHALL hold the state typedef/encoding and the default ORDER and RATE_W constants.
REQ-036 The decimation counter and dec_stb generation SHALL be in the sub-module cic_dec_cnt, which has ports clk, rstn, clr, vld, rate and stb.

Verification
REQ-037 ORDER=3, rate_i=8, start, src_vld=1 -> FLUSH for 24 cycles with cic_zero=1, then the first 3 dec_stb pulses have out_vld=0, the 4th has out_vld=1, and strobes follow every 8 cycles.
REQ-038 rate_i=1 with start -> err_rate pulses once, state_o stays 00 and busy stays 0; repeat with rate_i=0 -> same response.
REQ-039 In RUN with R=4, stop at counter=1 -> the FSM stays in RUN until the next dec_stb, which has out_vld=1, then state_o=00 the following cycle.
REQ-040 In RUN with R=5, src_vld toggling 1/0 -> dec_stb every 10 cycles, and cic_en mirrors src_vld.
REQ-041 rstn pulled low for 1 cycle mid-FLUSH and mid-RUN -> all outputs 0 asynchronously, and a restart with R=2 flushes 6 cycles.
REQ-042 With CIC_CTRL_SAMPLE_CNT_EN defined and R=4 for 100 strobes after settle -> sample_cnt=100, cleared to 0 by the next start.
